sd_frame_seq: RTL

Command sequencer that sits directly upstream of the SD SPI interface block and drives its action, flow-control and image-select inputs. After reset it initialises the card once. It then loads one image per frame by issuing 300 alternating read-command / 512-byte-stream operations and flags the last block with `end_of_frame`. Image selection advances either on a user pulse or on a slideshow timer.

---
 rtl/sd_frame_seq_pkg.sv | 30 +++
 rtl/sd_op_handshake.sv | 106 ++++++++++
 rtl/sd_frame_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sd_frame_seq_pkg.sv
// Shared encodings and state types for the SD frame command sequencer.
// Block stride constant is also used by the interface's block-index arithmetic.
package sd_frame_seq_pkg;

    localparam logic [2:0] OP_NONE   = 3'b000;
    localparam logic [2:0] OP_INIT   = 3'b001;
    localparam logic [2:0] OP_RDCMD  = 3'b010;
    localparam logic [2:0] OP_STREAM = 3'b100;

    localparam int BLKS_PER_FRAME_DEF = 300;

    typedef enum logic [2:0] {
        S_BOOT,
        S_INIT,
        S_IDLE,
        S_RD,
        S_ST,
        S_HOLD,
        S_ERR
    } seq_state_e;

    typedef enum logic [2:0] {
        H_IDLE,
        H_SETUP,
        H_ACK,
        H_DONE,
        H_ERR
    } hs_state_e;

endpackage

// File: rtl/sd_op_handshake.sv
// Single-op handshake with the SD SPI interface: setup, issue, ack, done.
// Op bits lead if_begin by one cycle since the interface samples them late.
module sd_op_handshake
    import sd_frame_seq_pkg::*;
#(
    parameter int ACK_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_go,
    input  logic [2:0] i_op,
    input  logic       i_eof,
    input  logic       i_busy,
    output logic [2:0] o_op,
    output logic       o_begin,
    output logic       o_eof,
    output logic       o_idle,
    output logic       o_done,
    output logic       o_err
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    hs_state_e      r_state;
    hs_state_e      w_nxt;
    logic [CW-1:0]  r_cnt;
    logic [2:0]     r_op;
    logic           r_begin;
    logic           r_eof;
    logic           w_tmo;

    always_comb begin
        w_nxt  = r_state;
        o_done = 1'b0;
        o_err  = 1'b0;
        w_tmo  = (r_cnt == CW'(ACK_TIMEOUT - 1));
        unique case (r_state)
            H_IDLE:  if (i_go) w_nxt = H_SETUP;
            H_SETUP: w_nxt = H_ACK;
            H_ACK: begin
                if (i_busy) begin
                    w_nxt = H_DONE;
                end else if (w_tmo) begin
                    w_nxt = H_ERR;
                    o_err = 1'b1;
                end
            end
            H_DONE: begin
                if (!i_busy) begin
                    w_nxt  = H_IDLE;
                    o_done = 1'b1;
                end
            end
            H_ERR:   w_nxt = H_ERR;
            default: w_nxt = H_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= H_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_NONE;
            r_begin <= 1'b0;
            r_eof   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            case (r_state)
                H_IDLE: begin
                    if (i_go) begin
                        r_op  <= i_op;
                        r_eof <= i_eof;
                    end
                end
                H_SETUP: begin
                    r_begin <= 1'b1;
                    r_cnt   <= '0;
                end
                H_ACK: begin
                    if (i_busy) begin
                        r_begin <= 1'b0;
                    end else if (w_tmo) begin
                        r_begin <= 1'b0;
                        r_op    <= OP_NONE;
                        r_eof   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                H_DONE: begin
                    if (!i_busy) begin
                        r_op  <= OP_NONE;
                        r_eof <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_op    = r_op;
    assign o_begin = r_begin;
    assign o_eof   = r_eof;
    assign o_idle  = (r_state == H_IDLE);

endmodule

// File: rtl/sd_frame_seq.sv
// SD frame sequencer: card init, then 2*BLKS_PER_FRAME ops per image.
// Define SLIDESHOW_EN to add a HOLD dwell timer that auto-advances the image.
module sd_frame_seq
    import sd_frame_seq_pkg::*;
#(
    parameter int BLKS_PER_FRAME = BLKS_PER_FRAME_DEF,
    parameter int NUM_IMG        = 16,
    parameter int HOLD_CYCLES    = 50_000_000,
    parameter int ACK_TIMEOUT    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       next_img,
    output logic       init,
    output logic       read_cmd,
    output logic       stream_512B,
    output logic       end_of_frame,
    output logic [3:0] img_id,
    output logic       if_begin,
    input  logic       if_busy,
    output logic       init_done,
    output logic       frame_done,
    output logic       err
);

    seq_state_e r_state;
    seq_state_e w_nxt;
    logic [8:0] r_blk;
    logic [3:0] r_img;
    logic       r_load;
    logic       r_pend;
    logic       r_init_done;
    logic       r_frame_done;
    logic       r_err;
    logic       w_go;
    logic [2:0] w_op;
    logic       w_eof;
    logic       w_last;
    logic       w_adv;
    logic [2:0] w_hs_op;
    logic       w_hs_idle;
    logic       w_done;
    logic       w_hs_err;

    assign w_last = (r_blk == 9'(BLKS_PER_FRAME - 1));

`ifdef SLIDESHOW_EN
    logic [31:0] r_hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
        end else if (r_state != S_HOLD) begin
            r_hold_cnt <= '0;
        end else begin
            r_hold_cnt <= r_hold_cnt + 32'd1;
        end
    end

    assign w_adv = r_pend || next_img ||
                   (r_hold_cnt == 32'(HOLD_CYCLES - 1));
`else
    logic w_unused_hold;
    assign w_unused_hold = ^32'(HOLD_CYCLES);
    assign w_adv = r_pend || next_img;
`endif

    // An op is launched whenever its state is active and the handshake is free
    always_comb begin
        w_nxt = r_state;
        w_go  = 1'b0;
        w_op  = OP_NONE;
        w_eof = 1'b0;
        unique case (r_state)
            S_BOOT: begin
                w_go  = 1'b1;
                w_op  = OP_INIT;
                w_nxt = S_INIT;
            end
            S_INIT: begin
                w_op = OP_INIT;
                w_go = w_hs_idle;
                if (w_done) w_nxt = S_IDLE;
            end
            S_IDLE: if (start && r_load) w_nxt = S_RD;
            S_RD: begin
                w_op = OP_RDCMD;
                w_go = w_hs_idle;
                if (w_done) w_nxt = S_ST;
            end
            S_ST: begin
                w_op  = OP_STREAM;
                w_eof = w_last;
                w_go  = w_hs_idle;
                if (w_done) w_nxt = w_last ? S_HOLD : S_RD;
            end
            S_HOLD:  if (w_adv) w_nxt = S_IDLE;
            S_ERR:   w_nxt = S_ERR;
            default: w_nxt = S_BOOT;
        endcase
        if (w_hs_err) w_nxt = S_ERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_BOOT;
            r_blk        <= '0;
            r_img        <= '0;
            r_load       <= 1'b1;
            r_pend       <= 1'b0;
            r_init_done  <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_nxt;
            r_frame_done <= (r_state == S_ST) && w_done && w_last;
            if (r_state == S_INIT && w_done) r_init_done <= 1'b1;
            if (w_hs_err) r_err <= 1'b1;
            if (r_state == S_IDLE && w_nxt == S_RD) begin
                r_blk  <= '0;
                r_load <= 1'b0;
            end else if (r_state == S_ST && w_done && !w_last && r_blk != '1) begin
                r_blk <= r_blk + 9'd1;
            end
            if (r_state == S_HOLD && w_adv) begin
                r_img  <= (r_img == 4'(NUM_IMG - 1)) ? 4'd0 : r_img + 4'd1;
                r_load <= 1'b1;
                r_pend <= 1'b0;
            end else if (next_img) begin
                r_pend <= 1'b1;
            end
        end
    end

    sd_op_handshake #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_hs (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_go   (w_go),
        .i_op   (w_op),
        .i_eof  (w_eof),
        .i_busy (if_busy),
        .o_op   (w_hs_op),
        .o_begin(if_begin),
        .o_eof  (end_of_frame),
        .o_idle (w_hs_idle),
        .o_done (w_done),
        .o_err  (w_hs_err)
    );

    assign init        = w_hs_op[0];
    assign read_cmd    = w_hs_op[1];
    assign stream_512B = w_hs_op[2];
    assign img_id      = r_img;
    assign init_done   = r_init_done;
    assign frame_done  = r_frame_done;
    assign err         = r_err;

endmodule
